// File: rtl/ptmch_trg_arb.sv
// ---------------------------------------------------------------------------
// ptmch_trg_arb
//   Event scheduler that sits after the pattern-match trigger block. Rising
//   edges on the per-instruction trigger pulses are captured as one pending
//   event per channel and handed round-robin to a single consumer over a
//   REQ/ACK handshake. Saturating per-channel grant counters and sticky
//   overflow flags are kept for host readback. Single clock domain (CLK160M).
//
// Optional feature macro: PTMCH_TRG_ARB_TMO_EN
//   Defined     : an 8-bit wait counter aborts a request after TMO_CYC cycles
//                 without ACK and sets the sticky TMO flag.
//   Not defined : a request waits for ACK forever and TMO is tied to 0.
//
// Ports
//   CLK160M    in   system clock
//   RESET      in   asynchronous reset, active-high
//   TRG_PLS    in   [NUM_CH] trigger pulses, high for >= 1 cycle per event
//   CH_MASK    in   [NUM_CH] 1 = channel enabled for edge capture
//   EVT_REQ    out  event request to the consumer
//   EVT_CH     out  [3] channel index of the current request
//   EVT_ACK    in   consumer accept, only looked at while EVT_REQ = 1
//   PEND       out  [NUM_CH] pending-event bits
//   OVF        out  [NUM_CH] sticky: edge arrived while already pending
//   TMO        out  sticky ACK-timeout flag
//   CNT_CLR    in   one-cycle pulse clearing counters, OVF and TMO
//   CNT_SEL    in   [3] counter readback select
//   CNT_RDATA  out  [CNT_W] selected counter, 0 for unused selects
//   BUSY       out  1 whenever the arbiter FSM is not idle
// ---------------------------------------------------------------------------
module ptmch_trg_arb #(
  parameter int NUM_CH  = 5,
  parameter int CNT_W   = 16,
  parameter int GAP_CYC = 4,
  parameter int TMO_CYC = 255
) (
  input  logic              CLK160M,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] TRG_PLS,
  input  logic [NUM_CH-1:0] CH_MASK,
  output logic              EVT_REQ,
  output logic [2:0]        EVT_CH,
  input  logic              EVT_ACK,
  output logic [NUM_CH-1:0] PEND,
  output logic [NUM_CH-1:0] OVF,
  output logic              TMO,
  input  logic              CNT_CLR,
  input  logic [2:0]        CNT_SEL,
  output logic [CNT_W-1:0]  CNT_RDATA,
  output logic              BUSY
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_GAP} state_t;

  // GAP lasts GAP_CYC cycles: it is entered with GAP_CYC-1 and left at 0.
  localparam logic [3:0] GAP_LOAD = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;

  // Elaboration-time guard on the supported parameter ranges.
  if (NUM_CH < 1 || NUM_CH > 8 || GAP_CYC < 0 || GAP_CYC > 15 ||
      TMO_CYC < 1 || TMO_CYC > 255) begin : gParamCheck
    $error("ptmch_trg_arb: parameter out of supported range");
  end

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   trg_q, trgDly_q, trgEdge_q;
  logic [NUM_CH-1:0]   pend_q, pend_d;
  logic [NUM_CH-1:0]   ovf_q, ovfSet;
  logic [NUM_CH-1:0]   grantClr;
  logic [2:0]          evtCh_q, evtCh_d;
  logic [2:0]          lastGrant_q, lastGrant_d;
  logic [3:0]          gapCnt_q, gapCnt_d;
  logic [CNT_W-1:0]    cnt_q [NUM_CH];
  logic                grantValid;
  logic [2:0]          grantCh;
  logic                incEn;
  logic                tmoFire;
  int                  rrIdx;

`ifdef PTMCH_TRG_ARB_TMO_EN
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);
  logic [7:0] waitCnt_q, waitCnt_d;
  logic       tmo_q;
`endif

  // Round-robin pick: walk the channels starting one past the last grant and
  // take the first pending one. The inner loop keeps every index constant.
  always_comb begin
    grantValid = 1'b0;
    grantCh    = '0;
    rrIdx      = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      rrIdx = int'(lastGrant_q) + 1 + i;
      if (rrIdx >= NUM_CH) rrIdx = rrIdx - NUM_CH;
      for (int j = 0; j < NUM_CH; j++) begin
        if (!grantValid && (j == rrIdx) && pend_q[j]) begin
          grantValid = 1'b1;
          grantCh    = 3'(j);
        end
      end
    end
  end

  // Arbiter FSM next state. A request ends either on ACK or, when the timeout
  // is built, after TMO_CYC unanswered cycles; both hand the turn onwards.
  always_comb begin
    state_d     = state_q;
    evtCh_d     = evtCh_q;
    lastGrant_d = lastGrant_q;
    gapCnt_d    = gapCnt_q;
    grantClr    = '0;
    incEn       = 1'b0;
    tmoFire     = 1'b0;
`ifdef PTMCH_TRG_ARB_TMO_EN
    waitCnt_d   = waitCnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grantValid) begin
          for (int j = 0; j < NUM_CH; j++) begin
            if (grantCh == 3'(j)) grantClr[j] = 1'b1;
          end
          evtCh_d = grantCh;
          state_d = ST_REQ;
`ifdef PTMCH_TRG_ARB_TMO_EN
          waitCnt_d = '0;
`endif
        end
      end
      ST_REQ: begin
        if (EVT_ACK) begin
          incEn       = 1'b1;
          lastGrant_d = evtCh_q;
          gapCnt_d    = GAP_LOAD;
          state_d     = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
        end
`ifdef PTMCH_TRG_ARB_TMO_EN
        else if (waitCnt_q == TMO_LAST) begin
          tmoFire     = 1'b1;
          lastGrant_d = evtCh_q;
          gapCnt_d    = GAP_LOAD;
          state_d     = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
        end else begin
          waitCnt_d = waitCnt_q + 8'd1;
        end
`endif
      end
      ST_GAP: begin
        if (gapCnt_q == 4'd0) state_d = ST_IDLE;
        else                  gapCnt_d = gapCnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // An edge landing in the same cycle the grant clears that channel re-arms
  // the pending bit instead of counting as an overflow.
  always_comb begin
    pend_d = (pend_q & ~grantClr) | trgEdge_q;
    ovfSet = trgEdge_q & pend_q & ~grantClr;
  end

  // Edge capture, pending/overflow bits and the FSM registers.
  always_ff @(posedge CLK160M or posedge RESET) begin
    if (RESET) begin
      trg_q       <= '0;
      trgDly_q    <= '0;
      trgEdge_q   <= '0;
      pend_q      <= '0;
      ovf_q       <= '0;
      state_q     <= ST_IDLE;
      evtCh_q     <= '0;
      lastGrant_q <= 3'(NUM_CH - 1);
      gapCnt_q    <= '0;
    end else begin
      trg_q       <= TRG_PLS;
      trgDly_q    <= trg_q;
      trgEdge_q   <= trg_q & ~trgDly_q & CH_MASK;
      pend_q      <= pend_d;
      ovf_q       <= CNT_CLR ? '0 : (ovf_q | ovfSet);
      state_q     <= state_d;
      evtCh_q     <= evtCh_d;
      lastGrant_q <= lastGrant_d;
      gapCnt_q    <= gapCnt_d;
    end
  end

  // Per-channel grant counters: saturate at all-ones, clear beats increment.
  always_ff @(posedge CLK160M or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (CNT_CLR)
          cnt_q[i] <= '0;
        else if (incEn && (evtCh_q == 3'(i)) && (cnt_q[i] != '1))
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

`ifdef PTMCH_TRG_ARB_TMO_EN
  // Request wait counter and sticky timeout flag.
  always_ff @(posedge CLK160M or posedge RESET) begin
    if (RESET) begin
      waitCnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      waitCnt_q <= waitCnt_d;
      tmo_q     <= CNT_CLR ? 1'b0 : (tmo_q | tmoFire);
    end
  end
  assign TMO = tmo_q;
`else
  assign TMO = 1'b0;
`endif

  // Counter readback mux; selects beyond the channel count read as zero.
  always_comb begin
    CNT_RDATA = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (CNT_SEL == 3'(i)) CNT_RDATA = cnt_q[i];
    end
  end

  assign EVT_REQ = (state_q == ST_REQ);
  assign EVT_CH  = evtCh_q;
  assign PEND    = pend_q;
  assign OVF     = ovf_q;
  assign BUSY    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ptmch_trg_arb.sv
// ---------------------------------------------------------------------------
// tb_ptmch_trg_arb
//   Directed bench for ptmch_trg_arb (NUM_CH=5, CNT_W=4, GAP_CYC=4,
//   TMO_CYC=8). Expected grant channels are queued as triggers are driven and
//   popped by a monitor on every rising EVT_REQ; flags and counters are
//   checked against constants derived from the intended behaviour.
// ---------------------------------------------------------------------------
module tb_ptmch_trg_arb;

  logic       clk = 1'b0;
  logic       RESET;
  logic [4:0] TRG_PLS;
  logic [4:0] CH_MASK;
  logic       EVT_REQ;
  logic [2:0] EVT_CH;
  logic       EVT_ACK;
  logic [4:0] PEND;
  logic [4:0] OVF;
  logic       TMO;
  logic       CNT_CLR;
  logic [2:0] CNT_SEL;
  logic [3:0] CNT_RDATA;
  logic       BUSY;

  int sb[$];
  int riseCyc[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n;
  logic reqPrev = 1'b0;

  ptmch_trg_arb #(
    .NUM_CH (5),
    .CNT_W  (4),
    .GAP_CYC(4),
    .TMO_CYC(8)
  ) dut (
    .CLK160M  (clk),
    .RESET    (RESET),
    .TRG_PLS  (TRG_PLS),
    .CH_MASK  (CH_MASK),
    .EVT_REQ  (EVT_REQ),
    .EVT_CH   (EVT_CH),
    .EVT_ACK  (EVT_ACK),
    .PEND     (PEND),
    .OVF      (OVF),
    .TMO      (TMO),
    .CNT_CLR  (CNT_CLR),
    .CNT_SEL  (CNT_SEL),
    .CNT_RDATA(CNT_RDATA),
    .BUSY     (BUSY)
  );

  // 160 MHz is not needed in simulation; a 10 ns period keeps numbers simple.
  always #5 clk = ~clk;

  // Free-running cycle count, used to measure grant spacing.
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] trg, input logic [4:0] mask, input logic ack);
    TRG_PLS = trg;
    CH_MASK = mask;
    EVT_ACK = ack;
  endtask

  task automatic pulseTrg(input logic [4:0] m);
    TRG_PLS = m;
    tick(1);
    TRG_PLS = '0;
  endtask

  task automatic checkCnt(input string tag, input int ch, input int exp);
    CNT_SEL = 3'(ch);
    #1;
    checkOutput(tag, 32'(CNT_RDATA), 32'(exp));
  endtask

  task automatic waitReq(input string tag, input int maxCyc);
    for (int i = 0; i < maxCyc && !EVT_REQ; i++) tick(1);
    checkOutput(tag, 32'(EVT_REQ), 32'd1);
  endtask

  task automatic resetDut();
    RESET = 1'b1;
    tick(2);
    RESET = 1'b0;
    tick(1);
  endtask

  // Scoreboard monitor: each new request must match the oldest queued channel.
  always @(negedge clk) begin
    if (EVT_REQ && !reqPrev) begin
      riseCyc.push_back(cyc);
      checkOutput("grantExpected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) checkOutput("grantCh", 32'(EVT_CH), 32'(sb.pop_front()));
    end
    reqPrev = EVT_REQ;
  end

  initial begin
    RESET   = 1'b1;
    CNT_CLR = 1'b0;
    CNT_SEL = '0;
    applyStimulus(5'h00, 5'h1F, 1'b0);
    tick(3);
    RESET = 1'b0;
    tick(1);
    $display("[TB] reset state");
    checkOutput("rstReq", 32'(EVT_REQ), 32'd0);
    checkOutput("rstCh", 32'(EVT_CH), 32'd0);
    checkOutput("rstPend", 32'(PEND), 32'd0);
    checkOutput("rstOvf", 32'(OVF), 32'd0);
    checkOutput("rstTmo", 32'(TMO), 32'd0);
    checkOutput("rstBusy", 32'(BUSY), 32'd0);
    for (int c = 0; c < 5; c++) checkCnt("rstCnt", c, 0);

    $display("[TB] T1 single long pulse on ch3");
    sb.push_back(3);
    applyStimulus(5'h08, 5'h1F, 1'b0);
    tick(2);
    checkOutput("t1PendEarly", 32'(PEND), 32'd0);
    tick(1);
    checkOutput("t1PendSet", 32'(PEND), 32'h08);
    tick(1);
    checkOutput("t1Req", 32'(EVT_REQ), 32'd1);
    checkOutput("t1Ch", 32'(EVT_CH), 32'd3);
    checkOutput("t1PendClr", 32'(PEND), 32'd0);
    tick(1);
    EVT_ACK = 1'b1;
    tick(1);
    EVT_ACK = 1'b0;
    checkOutput("t1ReqDrop", 32'(EVT_REQ), 32'd0);
    checkOutput("t1BusyGap", 32'(BUSY), 32'd1);
    tick(10);
    TRG_PLS = '0;
    tick(10);
    checkCnt("t1Cnt3", 3, 1);
    checkOutput("t1Ovf", 32'(OVF), 32'd0);
    checkOutput("t1SbEmpty", 32'(sb.size()), 32'd0);

    $display("[TB] T2 round robin");
    resetDut();
    for (int c = 0; c < 5; c++) sb.push_back(c);
    riseCyc.delete();
    EVT_ACK = 1'b1;
    pulseTrg(5'h1F);
    tick(40);
    EVT_ACK = 1'b0;
    checkOutput("t2SbEmpty", 32'(sb.size()), 32'd0);
    checkOutput("t2Rises", 32'(riseCyc.size()), 32'd5);
    for (int k = 1; k < 5; k++)
      checkOutput("t2Spacing", 32'((riseCyc.size() > k) ? riseCyc[k] - riseCyc[k-1] : 0), 32'd6);
    for (int c = 0; c < 5; c++) checkCnt("t2Cnt", c, 1);
    checkCnt("t2Sel5", 5, 0);
    checkCnt("t2Sel7", 7, 0);

    $display("[TB] T3 overflow and counter clear");
    resetDut();
    sb.push_back(0);
    pulseTrg(5'h01);
    waitReq("t3Req0", 10);
    pulseTrg(5'h02);
    tick(4);
    pulseTrg(5'h02);
    tick(5);
    checkOutput("t3Pend", 32'(PEND), 32'h02);
    checkOutput("t3Ovf", 32'(OVF), 32'h02);
    checkOutput("t3ReqHeld", 32'(EVT_REQ), 32'd1);
    sb.push_back(1);
    EVT_ACK = 1'b1;
    tick(20);
    EVT_ACK = 1'b0;
    checkCnt("t3Cnt0", 0, 1);
    checkCnt("t3Cnt1", 1, 1);
    checkOutput("t3OvfSticky", 32'(OVF), 32'h02);
    checkOutput("t3PendDrained", 32'(PEND), 32'd0);
    CNT_CLR = 1'b1;
    tick(1);
    CNT_CLR = 1'b0;
    checkOutput("t3OvfClr", 32'(OVF), 32'd0);
    checkCnt("t3Cnt1Clr", 1, 0);

    $display("[TB] T3b edge coinciding with grant");
    sb.push_back(2);
    pulseTrg(5'h04);
    waitReq("t3bReq2", 10);
    pulseTrg(5'h01);
    tick(5);
    checkOutput("t3bPend0", 32'(PEND), 32'h01);
    sb.push_back(0);
    sb.push_back(0);
    EVT_ACK = 1'b1;
    tick(3);
    TRG_PLS = 5'h01;
    tick(1);
    TRG_PLS = '0;
    tick(2);
    checkOutput("t3bReq0", 32'(EVT_REQ), 32'd1);
    checkOutput("t3bCh0", 32'(EVT_CH), 32'd0);
    checkOutput("t3bPendKept", 32'(PEND), 32'h01);
    checkOutput("t3bNoOvf", 32'(OVF), 32'd0);
    tick(15);
    EVT_ACK = 1'b0;
    checkOutput("t3bSbEmpty", 32'(sb.size()), 32'd0);
    checkCnt("t3bCnt0", 0, 2);

    $display("[TB] T4 mask and saturation");
    CNT_CLR = 1'b1;
    tick(1);
    CNT_CLR = 1'b0;
    CH_MASK = 5'h1B;
    pulseTrg(5'h04);
    tick(8);
    checkOutput("t4MaskPend", 32'(PEND), 32'd0);
    checkOutput("t4MaskBusy", 32'(BUSY), 32'd0);
    checkCnt("t4MaskCnt", 2, 0);
    CH_MASK = 5'h1F;
    EVT_ACK = 1'b1;
    for (int e = 0; e < 17; e++) begin
      sb.push_back(0);
      pulseTrg(5'h01);
      tick(10);
    end
    EVT_ACK = 1'b0;
    checkCnt("t4Sat", 0, 15);
    checkOutput("t4SbEmpty", 32'(sb.size()), 32'd0);

    $display("[TB] T5 reset during request");
    sb.push_back(3);
    pulseTrg(5'h08);
    waitReq("t5Req3", 10);
    @(negedge clk);
    #1;
    RESET = 1'b1;
    #1;
    checkOutput("t5AsyncReq", 32'(EVT_REQ), 32'd0);
    checkOutput("t5AsyncBusy", 32'(BUSY), 32'd0);
    tick(2);
    RESET = 1'b0;
    tick(1);
    checkOutput("t5Pend", 32'(PEND), 32'd0);
    checkOutput("t5Ch", 32'(EVT_CH), 32'd0);
    checkOutput("t5Ovf", 32'(OVF), 32'd0);
    for (int c = 0; c < 5; c++) checkCnt("t5Cnt", c, 0);
    sb.push_back(0);
    sb.push_back(3);
    EVT_ACK = 1'b1;
    pulseTrg(5'h09);
    tick(20);
    EVT_ACK = 1'b0;
    checkOutput("t5SbEmpty", 32'(sb.size()), 32'd0);

`ifdef PTMCH_TRG_ARB_TMO_EN
    $display("[TB] T6 ACK timeout");
    sb.push_back(4);
    sb.push_back(1);
    pulseTrg(5'h12);
    waitReq("t6Req4", 10);
    n = 0;
    while (EVT_REQ && n < 20) begin
      n++;
      tick(1);
    end
    checkOutput("t6ReqLen", 32'(n), 32'd8);
    checkOutput("t6Tmo", 32'(TMO), 32'd1);
    checkCnt("t6Cnt4", 4, 0);
    EVT_ACK = 1'b1;
    tick(15);
    EVT_ACK = 1'b0;
    checkCnt("t6Cnt1", 1, 1);
    checkOutput("t6SbEmpty", 32'(sb.size()), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
